systolic_input_feeder: RTL and testbench

SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

---
 rtl/vTPU_pkg.sv | 14 +
 rtl/systolic_input_feeder.sv | 167 ++++++++++++++++
 tb/tb_systolic_input_feeder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vTPU_pkg.sv
// vTPU_pkg: shared datapath types for the vTPU blocks.
// Holds the byte lane type and the input feeder FSM state encoding.
package vTPU_pkg;

  typedef logic [7:0] BYTE_TYPE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } FEEDER_STATE_TYPE;

endpackage

// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: streams rows from a buffer into the systolic skew stage, then flushes zeros.
// Optional stall statistics output when SYSTOLIC_FEEDER_STALL_CNT_EN is defined.
module systolic_input_feeder
  import vTPU_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [LEN_WIDTH-1:0]              row_count,
  input  logic                              stall,
  output logic                              buf_rd_en,
  output logic [ADDR_WIDTH-1:0]             buf_rd_addr,
  input  BYTE_TYPE [0:MATRIX_WIDTH-1]       buf_rd_data,
  output BYTE_TYPE [0:MATRIX_WIDTH-1]       data_output,
  output logic                              setup_enable,
  output logic                              busy,
  output logic                              done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cycles
`endif
);

  // The flush phase lasts MATRIX_WIDTH-1 unstalled cycles; the counter stops at the last one.
  localparam int FLUSH_LAST = MATRIX_WIDTH - 2;
  localparam int FCNT_W     = (MATRIX_WIDTH > 2) ? $clog2(MATRIX_WIDTH - 1) : 1;

  FEEDER_STATE_TYPE            state_reg, state_next;
  logic [LEN_WIDTH-1:0]        rd_left_reg;
  logic [ADDR_WIDTH-1:0]       rd_addr_reg;
  logic [FCNT_W-1:0]           flush_cnt_reg;
  logic                        pend_reg;
  logic                        hold_valid_reg;
  BYTE_TYPE [0:MATRIX_WIDTH-1] hold_data_reg;

  logic start_accept;
  logic rd_fire;
  logic out_valid;
  logic row_accept;
  logic last_accept;
  logic flush_step;
  logic flush_last;

  assign start_accept = (state_reg == IDLE) && start;
  assign rd_fire      = (state_reg == STREAM) && !stall && (rd_left_reg != '0);
  // Read data is presented live in its arrival cycle and parked in the hold register if stalled.
  assign out_valid    = pend_reg || hold_valid_reg;
  assign row_accept   = (state_reg == STREAM) && out_valid && !stall;
  assign last_accept  = row_accept && (rd_left_reg == '0);
  assign flush_step   = (state_reg == FLUSH) && !stall;
  assign flush_last   = flush_step && (flush_cnt_reg == FCNT_W'(FLUSH_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (row_count != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (last_accept) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_left_reg <= '0;
      rd_addr_reg <= '0;
    end else if (start_accept) begin
      rd_left_reg <= row_count;
      rd_addr_reg <= base_addr;
    end else if (rd_fire) begin
      rd_left_reg <= rd_left_reg - LEN_WIDTH'(1);
      rd_addr_reg <= rd_addr_reg + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_reg <= '0;
    end else if (start_accept || flush_last) begin
      flush_cnt_reg <= '0;
    end else if (flush_step) begin
      flush_cnt_reg <= flush_cnt_reg + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg       <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else begin
      pend_reg <= rd_fire;
      if (start_accept) begin
        hold_valid_reg <= 1'b0;
      end else if (pend_reg && stall) begin
        hold_valid_reg <= 1'b1;
        hold_data_reg  <= buf_rd_data;
      end else if (hold_valid_reg && !stall) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    data_output = '0;
    if (state_reg == STREAM) begin
      if (hold_valid_reg) begin
        data_output = hold_data_reg;
      end else if (pend_reg) begin
        data_output = buf_rd_data;
      end
    end
  end

  assign buf_rd_en    = rd_fire;
  assign buf_rd_addr  = rd_addr_reg;
  assign setup_enable = row_accept || flush_step;
  assign busy         = (state_reg == STREAM) || (state_reg == FLUSH);
  assign done         = (state_reg == DONE);

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (start_accept) begin
      stall_cnt_reg <= '0;
    end else if (busy && stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb_systolic_input_feeder: scoreboard bench for systolic_input_feeder with a behavioural buffer model.
// Covers directed timing scenarios plus randomized transfers with random stall and stray starts.
module tb_systolic_input_feeder;
  import vTPU_pkg::*;

  localparam int MW      = 14;
  localparam int AW      = 24;
  localparam int LW      = 16;
  localparam int RB      = MW * 8;
  localparam int SNAP    = 64;
  localparam int TIMEOUT = 2000;

  typedef logic [RB-1:0] row_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] row_count = '0;
  logic buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  BYTE_TYPE [0:MW-1] buf_rd_data = '0;
  BYTE_TYPE [0:MW-1] data_output;
  logic setup_enable;
  logic busy;
  logic done;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  systolic_input_feeder #(
    .MATRIX_WIDTH(MW),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .row_count   (row_count),
    .stall       (stall),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .data_output (data_output),
    .setup_enable(setup_enable),
    .busy        (busy),
    .done        (done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] seed = 32'h1;
  int start_cyc = 0;
  int busy_cnt, stall_cnt, done_rel;
  bit done_seen;
  int cur_n;
  logic [AW-1:0] cur_base;

  logic [AW-1:0] exp_addr[$];
  row_t exp_row[$];
  int exp_done[$];
  int rd_log[$];
  int se_log[$];
  logic [AW-1:0] rda_log[$];
  row_t snap_data[SNAP];
  bit snap_se[SNAP];
  logic [31:0] snap_sc[SNAP];

  // Buffer contents are a pure function of address and a per-transfer seed.
  function automatic row_t row_of(input logic [AW-1:0] a, input logic [31:0] s);
    logic [31:0] h;
    logic [127:0] w;
    h = ({8'h00, a} * 32'h9E3779B1) ^ s;
    w = {h, h ^ 32'hA5A5A5A5, ~h, h + 32'h01234567};
    return w[RB-1:0];
  endfunction

  function automatic row_t garbage();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[RB-1:0];
  endfunction

  // Buffer model: data valid only in the cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= row_of(buf_rd_addr, seed);
    else           buf_rd_data <= garbage();
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic bit stall_at(input int mode, input int rel);
    if (mode == 1) return (rel >= 2 && rel <= 4);
    if (mode == 2) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic monitor_loop();
    int rel;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        rel = cyc - start_cyc;
        if (rel >= 0 && rel < SNAP) begin
          snap_data[rel] = row_t'(data_output);
          snap_se[rel]   = setup_enable;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
          snap_sc[rel]   = stall_cycles;
`else
          snap_sc[rel]   = 32'd0;
`endif
        end
        if (!busy) chk("idle_quiet", 128'({setup_enable, row_t'(data_output)}), 128'(0));
        if (!setup_enable && !stall) chk("no_valid_zero", 128'(row_t'(data_output)), 128'(0));
        if (buf_rd_en) begin
          rd_log.push_back(rel);
          rda_log.push_back(buf_rd_addr);
          chk("rd_while_stall", 128'(stall), 128'(0));
          if (exp_addr.size() == 0) fail_now("rd_unexpected", $sformatf("read of %0h with none expected", buf_rd_addr));
          else chk("rd_addr", 128'(buf_rd_addr), 128'(exp_addr.pop_front()));
        end
        if (setup_enable) begin
          se_log.push_back(rel);
          chk("se_while_stall", 128'(stall), 128'(0));
          if (exp_row.size() == 0) fail_now("se_unexpected", $sformatf("setup_enable at rel %0d with none expected", rel));
          else chk("row_data", 128'(row_t'(data_output)), 128'(exp_row.pop_front()));
        end
        if (busy) begin
          busy_cnt++;
          if (stall) stall_cnt++;
        end
        if (done) begin
          done_rel  = rel;
          done_seen = 1'b1;
          chk("done_not_busy", 128'(busy), 128'(0));
          if (exp_done.size() == 0) fail_now("done_unexpected", $sformatf("done at rel %0d", rel));
          else chk("unstalled_busy_cycles", 128'(busy_cnt - stall_cnt), 128'(exp_done.pop_front()));
          chk("reads_left", 128'(exp_addr.size()), 128'(0));
          chk("rows_left", 128'(exp_row.size()), 128'(0));
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
          chk("stall_cycles", 128'(stall_cycles), 128'(stall_cnt));
`endif
          $display("xfer base=%06h rows=%0d done at rel cycle %0d, stalled busy cycles %0d",
                   cur_base, cur_n, rel, stall_cnt);
        end
      end
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                          input int abort_rel, input bit rel_reset);
    int rel;
    @(posedge clk);
    #1;
    seed = $urandom;
    cur_base = b;
    cur_n = n;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_row.push_back(row_of(a, seed));
    end
    if (n > 0) for (int i = 0; i < MW - 1; i++) exp_row.push_back('0);
    exp_done.push_back((n == 0) ? 0 : n + MW);
    busy_cnt = 0;
    stall_cnt = 0;
    done_seen = 1'b0;
    done_rel = -1;
    rd_log.delete();
    se_log.delete();
    rda_log.delete();
    for (int i = 0; i < SNAP; i++) begin
      snap_se[i] = 1'b0;
      snap_data[i] = '0;
      snap_sc[i] = 32'hDEAD_BEEF;
    end
    start_cyc = cyc;
    if (rel_reset) reset = 1'b1;
    start = 1'b1;
    base_addr = b;
    row_count = LW'(n);
    stall = stall_at(mode, 0);
    rel = 0;
    forever begin
      @(posedge clk);
      #1;
      rel++;
      if (done_seen) break;
      if (rel > TIMEOUT) begin
        fail_now("timeout", $sformatf("no done within %0d cycles", TIMEOUT));
        break;
      end
      if (rel == abort_rel) begin
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst_rd_en", 128'(buf_rd_en), 128'(0));
        chk("rst_rd_addr", 128'(buf_rd_addr), 128'(0));
        chk("rst_setup_en", 128'(setup_enable), 128'(0));
        chk("rst_data", 128'(row_t'(data_output)), 128'(0));
        chk("rst_busy_done", 128'({busy, done}), 128'(0));
        exp_addr.delete();
        exp_row.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      start = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      base_addr = $urandom;
      row_count = $urandom;
      stall = stall_at(mode, rel);
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("init_outputs", 128'({buf_rd_en, buf_rd_addr, setup_enable, busy, done}), 128'(0));
    chk("init_data", 128'(row_t'(data_output)), 128'(0));

    // Nominal 4-row transfer, reset released together with start.
    run_xfer(24'h000100, 4, 0, -1, 1'b1);
    chk("t1_reads", 128'(rd_log.size()), 128'(4));
    if (rd_log.size() == 4) begin
      chk("t1_first_rd", 128'(rd_log[0]), 128'(1));
      chk("t1_last_rd", 128'(rd_log[3]), 128'(4));
    end
    chk("t1_se_count", 128'(se_log.size()), 128'(17));
    if (se_log.size() == 17) begin
      chk("t1_first_se", 128'(se_log[0]), 128'(2));
      chk("t1_last_se", 128'(se_log[16]), 128'(18));
    end
    chk("t1_flush_zero6", 128'({snap_se[6], snap_data[6]}), 128'({1'b1, row_t'(0)}));
    chk("t1_done_rel", 128'(done_rel), 128'(19));

    // Empty transfer.
    run_xfer(24'h000055, 0, 0, -1, 1'b0);
    chk("t2_done_rel", 128'(done_rel), 128'(1));
    chk("t2_reads", 128'(rd_log.size()), 128'(0));
    chk("t2_se", 128'(se_log.size()), 128'(0));
    chk("t2_busy", 128'(busy_cnt), 128'(0));

    // Stall over cycles 2..4.
    run_xfer(24'h000200, 3, 1, -1, 1'b0);
    for (int r = 2; r <= 4; r++) begin
      chk($sformatf("t3_hold_data_%0d", r), 128'(snap_data[r]), 128'(row_of(24'h000200, seed)));
      chk($sformatf("t3_hold_se_%0d", r), 128'(snap_se[r]), 128'(0));
    end
    chk("t3_accept_rel", 128'(se_log.size() > 0 ? se_log[0] : -1), 128'(5));
    chk("t3_done_rel", 128'(done_rel), 128'(21));
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("t3_stall_cycles", 128'(snap_sc[21]), 128'(3));
`endif

    // Address wrap.
    run_xfer(24'hFFFFFE, 3, 0, -1, 1'b0);
    chk("t4_reads", 128'(rda_log.size()), 128'(3));
    if (rda_log.size() == 3) chk("t4_wrap_addr", 128'(rda_log[2]), 128'(0));
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("t4_stall_clear", 128'(snap_sc[1]), 128'(0));
`endif

    // Reset in FLUSH, then a clean transfer started on the first edge after release.
    run_xfer(24'h000300, 2, 0, 8, 1'b0);
    run_xfer(24'h000310, 5, 0, -1, 1'b1);
    chk("t5_done_rel", 128'(done_rel), 128'(20));

    // Randomized transfers with random stall and stray start pulses.
    for (int k = 0; k < 20; k++) begin
      run_xfer(AW'($urandom), $urandom_range(0, 20), 2, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
